bank_reg: RTL and testbench

- ARMv4-style general-purpose register file for the processor datapath.
- Holds R0–R14, with two combinational read ports and one synchronous write port.
- Register index 15 (PC) is not stored. Reads of index 15 return the externally supplied PC+8 value (PCplus).
- Sits between the decode stage (register addresses) and the ALU/writeback path.

---
 rtl/bank_reg_pkg.sv | 21 ++
 rtl/bank_reg_rdport.sv | 29 ++
 rtl/bank_reg.sv | 57 +++++
 tb/tb_bank_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bank_reg_pkg.sv
// Shared constants and types for the ARMv4-style register bank.
//   DATA_W     : register / data port width
//   ADDR_W     : register index width (16 architectural indices)
//   PC_IDX     : index that reads back PCplus instead of storage
//   NUM_REGS   : number of stored registers (R0-R14)
package bank_reg_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned PC_IDX   = 15;
    localparam int unsigned NUM_REGS = PC_IDX;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // Storage image handed to the read ports: element i holds R[i].
    typedef word_t [NUM_REGS-1:0] reg_array_t;

    localparam reg_addr_t PC_ADDR = reg_addr_t'(PC_IDX);

endpackage : bank_reg_pkg

// File: rtl/bank_reg_rdport.sv
// Combinational read port: selects R[addr], or pcplus for the PC index.
//   addr   : register index to read
//   regs   : current contents of R0-R14
//   pcplus : PC+8 value returned for the PC index
//   rd     : selected read data (zero latency)
module bank_reg_rdport
    import bank_reg_pkg::*;
(
    input  reg_addr_t  addr,
    input  reg_array_t regs,
    input  word_t      pcplus,
    output word_t      rd
);

    // Explicit compare-per-entry mux keeps every index in range; the PC
    // index has no storage entry and is resolved separately.
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == reg_addr_t'(i)) begin
                rd = regs[i];
            end
        end
        if (addr == PC_ADDR) begin
            rd = pcplus;
        end
    end

endmodule : bank_reg_rdport

// File: rtl/bank_reg.sv
// General-purpose register bank R0-R14 with two combinational read ports
// and one synchronous write port. Index 15 reads return PCplus and writes
// to it are dropped; the fetch unit owns the PC.
//   CLK    : clock, writes on rising edge
//   rst    : asynchronous active-low reset, clears R0-R14
//   A1/A2  : read addresses for RD1/RD2
//   A3     : write address
//   WD3    : write data
//   PCplus : PC+8, returned for reads of index 15
//   WE3    : write enable, active-high
//   RD1    : read data for A1 (combinational)
//   RD2    : read data for A2 (combinational)
module bank_reg
    import bank_reg_pkg::*;
(
    input  logic      CLK,
    input  logic      rst,
    input  reg_addr_t A1,
    input  reg_addr_t A2,
    input  reg_addr_t A3,
    input  word_t     WD3,
    input  word_t     PCplus,
    input  logic      WE3,
    output word_t     RD1,
    output word_t     RD2
);

    reg_array_t regs;

    // Write port; A3 = PC index matches no entry and is therefore ignored.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (WE3 && (A3 == reg_addr_t'(i))) begin
                    regs[i] <= WD3;
                end
            end
        end
    end

    bank_reg_rdport u_rdport1 (
        .addr   (A1),
        .regs   (regs),
        .pcplus (PCplus),
        .rd     (RD1)
    );

    bank_reg_rdport u_rdport2 (
        .addr   (A2),
        .regs   (regs),
        .pcplus (PCplus),
        .rd     (RD2)
    );

endmodule : bank_reg

// File: tb/tb_bank_reg.sv
// Directed self-checking bench for bank_reg.
module tb_bank_reg;
    import bank_reg_pkg::*;

    logic      CLK;
    logic      rst;
    reg_addr_t A1;
    reg_addr_t A2;
    reg_addr_t A3;
    word_t     WD3;
    word_t     PCplus;
    logic      WE3;
    word_t     RD1;
    word_t     RD2;

    int compared;
    int mismatched;

    bank_reg dut (
        .CLK    (CLK),
        .rst    (rst),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .WD3    (WD3),
        .PCplus (PCplus),
        .WE3    (WE3),
        .RD1    (RD1),
        .RD2    (RD2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset asserted from time zero
        rst    = 1'b0;
        WE3    = 1'b0;
        A1     = 4'd1;
        A2     = 4'd5;
        A3     = 4'd0;
        WD3    = 32'h0;
        PCplus = 32'hAAAA_AAAA;
        #1;
        check("reset_rd1_r1", RD1, 32'h0);
        check("reset_rd2_r5", RD2, 32'h0);
        A1 = 4'd15;
        #1;
        check("reset_rd1_r15", RD1, 32'hAAAA_AAAA);

        // Writes during reset are ignored
        WE3 = 1'b1;
        A3  = 4'd2;
        WD3 = 32'h0BAD_0BAD;
        A2  = 4'd2;
        @(posedge CLK); #1;
        check("reset_write_ignored", RD2, 32'h0);

        // Release between edges; the first edge after release writes R8
        @(negedge CLK);
        rst = 1'b1;
        A3  = 4'd8;
        WD3 = 32'hFFFC_0007;
        @(posedge CLK); #1;
        WE3 = 1'b0;
        A1  = 4'd8;
        A2  = 4'd1;
        #1;
        check("basic_write_r8", RD1, 32'hFFFC_0007);
        check("basic_r1_zero", RD2, 32'h0);
        A2 = 4'd5;
        #1;
        check("basic_r5_zero", RD2, 32'h0);

        // Write then disable
        @(negedge CLK);
        A3  = 4'd1;
        WD3 = 32'hF000_0007;
        WE3 = 1'b1;
        @(posedge CLK); #1;
        WE3 = 1'b0;
        WD3 = 32'h1234_5678;
        A1  = 4'd1;
        #1;
        check("wdis_r1_after_write", RD1, 32'hF000_0007);
        @(posedge CLK); #1;
        check("wdis_r1_held", RD1, 32'hF000_0007);

        // R15 writes dropped; reads follow PCplus combinationally
        @(negedge CLK);
        A3  = 4'd15;
        WD3 = 32'hDEAD_BEEF;
        WE3 = 1'b1;
        @(posedge CLK); #1;
        WE3    = 1'b0;
        A1     = 4'd15;
        PCplus = 32'h0000_2AAA;
        #1;
        check("r15_reads_pcplus", RD1, 32'h0000_2AAA);
        PCplus = 32'hAAAA_FFFF;
        #1;
        check("r15_follows_pcplus", RD1, 32'hAAAA_FFFF);
        A2 = 4'd14;
        #1;
        check("r15_write_no_r14", RD2, 32'h0);
        A2 = 4'd8;
        #1;
        check("r15_write_r8_kept", RD2, 32'hFFFC_0007);

        // Read-during-write, dual port on the same address
        @(negedge CLK);
        A1 = 4'd4;
        A2 = 4'd4;
        #1;
        check("rdw_rd1_before", RD1, 32'h0);
        check("rdw_rd2_before", RD2, 32'h0);
        WE3 = 1'b1;
        A3  = 4'd4;
        WD3 = 32'hF00F_F007;
        #1;
        check("rdw_no_bypass", RD1, 32'h0);
        @(posedge CLK); #1;
        WE3 = 1'b0;
        check("rdw_rd1_after", RD1, 32'hF00F_F007);
        check("rdw_rd2_after", RD2, 32'hF00F_F007);

        // Asynchronous reset mid-operation
        @(negedge CLK);
        A1 = 4'd8;
        #1;
        check("async_r8_before", RD1, 32'hFFFC_0007);
        #1;
        rst = 1'b0;
        #1;
        check("async_r8_cleared", RD1, 32'h0);
        A2 = 4'd15;
        #1;
        check("async_r15_pcplus", RD2, 32'hAAAA_FFFF);
        A2 = 4'd4;
        #1;
        check("async_r4_cleared", RD2, 32'h0);
        @(negedge CLK);
        rst = 1'b1;
        @(posedge CLK); #1;
        check("async_r8_stays_zero", RD1, 32'h0);

        // Release edge may write: R3 on the first edge, R8 untouched
        @(negedge CLK);
        rst = 1'b0;
        #1;
        @(negedge CLK);
        rst = 1'b1;
        WE3 = 1'b1;
        A3  = 4'd3;
        WD3 = 32'h5555_AAAA;
        A2  = 4'd3;
        @(posedge CLK); #1;
        WE3 = 1'b0;
        check("release_edge_write", RD2, 32'h5555_AAAA);
        check("release_r8_zero", RD1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_bank_reg
